ccr_shadow_stack: RTL and testbench

Parametrised condition-code register with a hardware shadow stack for nested interrupts. It holds NFLAGS architectural flags (bit 0 Z, bit 1 N, bit 2 C, bit 3 V, higher bits free for ISA extensions). Each flag updates from the ALU under a per-flag mask, or is set/cleared directly by flag instructions. On an interrupt the block saves the flag state into a DEPTH-entry LIFO, and on RTI it restores it. It sits between the ALU/writeback stage and the branch unit, replacing the single-level CCR.

---
 rtl/ccr_shadow_stack.sv | 118 +++++++++++
 tb/tb_ccr_shadow_stack.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ccr_shadow_stack.sv
// rtl/ccr_shadow_stack.sv - condition-code register with a LIFO shadow stack for nested interrupts
module ccr_shadow_stack #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NFLAGS-1:0] i_flags_in,
    input  logic              i_flag_en,
    input  logic [NFLAGS-1:0] i_flag_mask,
    input  logic [NFLAGS-1:0] i_flag_set,
    input  logic [NFLAGS-1:0] i_flag_clr,
    input  logic              i_intr,
    input  logic              i_rti,
    input  logic              i_err_clr,
    output logic [NFLAGS-1:0] o_ccr,
    output logic [CW-1:0]     o_depth,
    output logic              o_stack_empty,
    output logic              o_stack_full,
    output logic              o_ovf_err,
    output logic              o_unf_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] r_ccr;
    logic [CW-1:0]     r_depth;
    logic              r_ovf_err;
    logic              r_unf_err;
    logic [NFLAGS-1:0] r_stack [DEPTH];

    logic [NFLAGS-1:0] w_upd;
    logic [NFLAGS-1:0] w_nxt;
    logic [NFLAGS-1:0] w_top;
    logic [AW-1:0]     w_push_idx;
    logic [AW-1:0]     w_pop_idx;
    logic              w_empty;
    logic              w_full;
    logic [NFLAGS-1:0] w_ccr_d;
    logic [CW-1:0]     w_depth_d;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_unf_set;

    assign w_upd      = i_flag_en ? ((i_flags_in & i_flag_mask) | (r_ccr & ~i_flag_mask)) : r_ccr;
    // Clear is applied last so it beats set on the same bit.
    assign w_nxt      = (w_upd | i_flag_set) & ~i_flag_clr;
    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == CW'(DEPTH));
    assign w_push_idx = AW'(r_depth);
    assign w_pop_idx  = AW'(r_depth - CW'(1));
    assign w_top      = r_stack[w_pop_idx];

    always_comb begin
        w_ccr_d   = w_nxt;
        w_depth_d = r_depth;
        w_push    = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case ({i_intr, i_rti})
            2'b01: begin
                if (w_empty) begin
                    w_ccr_d   = r_ccr;
                    w_unf_set = 1'b1;
                end else begin
                    w_ccr_d   = w_top;
                    w_depth_d = r_depth - CW'(1);
                end
            end
            2'b10: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_depth_d = r_depth + CW'(1);
                end
            end
            // Tail-chain: reload the saved flags but keep them on the stack.
            2'b11: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_ccr_d = w_top;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ccr     <= '0;
            r_depth   <= '0;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            r_ccr     <= w_ccr_d;
            r_depth   <= w_depth_d;
            r_ovf_err <= w_ovf_set | (r_ovf_err & ~i_err_clr);
            r_unf_err <= w_unf_set | (r_unf_err & ~i_err_clr);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_stack[w_push_idx] <= w_nxt;
        end
    end

    assign o_ccr         = r_ccr;
    assign o_depth       = r_depth;
    assign o_stack_empty = w_empty;
    assign o_stack_full  = w_full;
    assign o_ovf_err     = r_ovf_err;
    assign o_unf_err     = r_unf_err;

endmodule

// File: tb/tb_ccr_shadow_stack.sv
// tb/tb_ccr_shadow_stack.sv - directed and randomized checks of ccr_shadow_stack against a queue model
module tb_ccr_shadow_stack;

    localparam int NF = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] flags_in, flag_mask, flag_set, flag_clr;
    logic          flag_en, intr, rti, err_clr;
    logic [NF-1:0] ccr;
    logic [CW-1:0] depth;
    logic          stack_empty, stack_full, ovf_err, unf_err;

    int checks = 0;
    int errors = 0;

    logic [NF-1:0] m_ccr;
    logic [NF-1:0] m_stk [$];
    logic          m_ovf, m_unf;

    always #5 clk = ~clk;

    ccr_shadow_stack #(.NFLAGS(NF), .DEPTH(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_flags_in(flags_in), .i_flag_en(flag_en),
        .i_flag_mask(flag_mask), .i_flag_set(flag_set), .i_flag_clr(flag_clr),
        .i_intr(intr), .i_rti(rti), .i_err_clr(err_clr),
        .o_ccr(ccr), .o_depth(depth), .o_stack_empty(stack_empty),
        .o_stack_full(stack_full), .o_ovf_err(ovf_err), .o_unf_err(unf_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fe, input logic [NF-1:0] fin,
                         input logic [NF-1:0] msk, input logic [NF-1:0] fs,
                         input logic [NF-1:0] fc, input logic it, input logic rt,
                         input logic ec);
        rst = r; flag_en = fe; flags_in = fin; flag_mask = msk;
        flag_set = fs; flag_clr = fc; intr = it; rti = rt; err_clr = ec;
    endtask

    task automatic model_step();
        logic [NF-1:0] upd, nxt;
        logic ovf_ev, unf_ev;
        if (rst) begin
            m_ccr = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
            return;
        end
        upd    = flag_en ? ((flags_in & flag_mask) | (m_ccr & ~flag_mask)) : m_ccr;
        nxt    = (upd | flag_set) & ~flag_clr;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (rti && !intr) begin
            if (m_stk.size() > 0) m_ccr = m_stk.pop_back();
            else unf_ev = 1'b1;
        end else if (intr && !rti) begin
            m_ccr = nxt;
            if (m_stk.size() < D) m_stk.push_back(nxt);
            else ovf_ev = 1'b1;
        end else if (intr && rti) begin
            if (m_stk.size() > 0) m_ccr = m_stk[m_stk.size()-1];
            else begin m_ccr = nxt; unf_ev = 1'b1; end
        end else begin
            m_ccr = nxt;
        end
        m_ovf = ovf_ev | (m_ovf & ~err_clr);
        m_unf = unf_ev | (m_unf & ~err_clr);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ccr"},   32'(ccr),         32'(m_ccr));
        chk({tag, ".depth"}, 32'(depth),       32'(m_stk.size()));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
        chk({tag, ".full"},  32'(stack_full),  32'(m_stk.size() == D));
        chk({tag, ".ovf"},   32'(ovf_err),     32'(m_ovf));
        chk({tag, ".unf"},   32'(unf_err),     32'(m_unf));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        m_ccr = '0; m_ovf = 1'b0; m_unf = 1'b0;

        // reset and masked update
        drive(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        step("rst0"); step("rst1");
        chk("rst.ccr", 32'(ccr), 32'h0);
        chk("rst.empty", 32'(stack_empty), 32'h1);
        drive(0, 1, 4'b1111, 4'b0101, 4'h0, 4'h0, 0, 0, 0); step("mask");
        chk("mask.ccr", 32'(ccr), 32'b0101);
        drive(0, 1, 4'b1111, 4'b0000, 4'h0, 4'h0, 0, 0, 0); step("mask0");
        chk("mask0.ccr", 32'(ccr), 32'b0101);

        // set/clr priority
        drive(0, 1, 4'b0000, 4'b1111, 4'h0, 4'h0, 0, 0, 0); step("zero");
        drive(0, 0, 4'b0000, 4'b0000, 4'b0011, 4'b0010, 0, 0, 0); step("setclr");
        chk("setclr.ccr", 32'(ccr), 32'b0001);
        drive(0, 1, 4'b0000, 4'b1111, 4'b1000, 4'h0, 0, 0, 0); step("setalu");
        chk("setalu.ccr", 32'(ccr), 32'b1000);

        // nesting
        drive(0, 1, 4'b0001, 4'b1111, 4'h0, 4'h0, 0, 0, 0); step("n_ld");
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0); step("n_push1");
        chk("n_push1.depth", 32'(depth), 32'd1);
        drive(0, 1, 4'b0110, 4'b1111, 4'h0, 4'h0, 1, 0, 0); step("n_push2");
        chk("n_push2.depth", 32'(depth), 32'd2);
        drive(0, 1, 4'b1111, 4'b1111, 4'h0, 4'h0, 0, 0, 0); step("n_alu");
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0); step("n_pop1");
        chk("n_pop1.ccr", 32'(ccr), 32'b0110);
        step("n_pop2");
        chk("n_pop2.ccr", 32'(ccr), 32'b0001);
        chk("n_pop2.empty", 32'(stack_empty), 32'h1);

        // overflow
        drive(0, 1, 4'b1010, 4'b1111, 4'h0, 4'h0, 0, 0, 0); step("o_ld");
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("o_push");
        chk("o.depth", 32'(depth), 32'd4);
        chk("o.full", 32'(stack_full), 32'h1);
        chk("o.ovf", 32'(ovf_err), 32'h1);
        chk("o.ccr", 32'(ccr), 32'b1010);
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step("o_pop");
            chk("o_pop.ccr", 32'(ccr), 32'b1010);
        end
        chk("o_pop.depth", 32'(depth), 32'd0);
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1); step("o_clr");
        chk("o_clr.ovf", 32'(ovf_err), 32'h0);

        // underflow and same-cycle events
        drive(0, 1, 4'b1111, 4'b1111, 4'h0, 4'h0, 0, 1, 0); step("u_rti");
        chk("u_rti.ccr", 32'(ccr), 32'b1010);
        chk("u_rti.unf", 32'(unf_err), 32'h1);
        drive(0, 1, 4'b0100, 4'b1111, 4'h0, 4'h0, 1, 0, 0); step("u_push");
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0); step("u_tail");
        chk("u_tail.ccr", 32'(ccr), 32'b0100);
        chk("u_tail.depth", 32'(depth), 32'd1);
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0); step("u_pop");
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 1); step("u_clrset");
        chk("u_clrset.unf", 32'(unf_err), 32'h1);

        // reset mid-run
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("r_push");
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0); step("r_pop");
        chk("r_pop.depth", 32'(depth), 32'd3);
        chk("r_pop.ovf", 32'(ovf_err), 32'h1);
        drive(1, 1, 4'b1111, 4'b1111, 4'b1111, 4'h0, 1, 0, 0); step("r_rst");
        chk("r_rst.ccr", 32'(ccr), 32'h0);
        chk("r_rst.depth", 32'(depth), 32'd0);
        chk("r_rst.ovf", 32'(ovf_err), 32'h0);
        drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0); step("r_unf");
        chk("r_unf.unf", 32'(unf_err), 32'h1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0,
                  ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0,
                  ($urandom_range(2) == 0), ($urandom_range(2) == 0),
                  ($urandom_range(7) == 0));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
